// File: rtl/ct_l2c_spsram_128x104_ctrl_pkg.sv
// Shared widths, depths and FSM encoding for the 128x104 SPSRAM access controller.
package ct_l2c_spsram_128x104_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 7;
    localparam int unsigned DATA_WIDTH = 104;
    localparam int unsigned SRAM_DEPTH = 128;
    localparam int unsigned RSP_DEPTH  = 2;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic {
        StInit = 1'b0,
        StIdle = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ct_l2c_spsram_128x104_ctrl_if.sv
// Request/response handshake plus SRAM pin bundle for the access controller.
interface ct_l2c_spsram_128x104_ctrl_if;
    import ct_l2c_spsram_128x104_ctrl_pkg::*;

    logic  init_req;
    logic  init_done;
    logic  req_vld;
    logic  req_rdy;
    logic  req_wr;
    addr_t req_addr;
    data_t req_wdata;
    data_t req_wmask;
    logic  rsp_vld;
    logic  rsp_rdy;
    data_t rsp_data;
    addr_t sram_a;
    logic  sram_cen;
    logic  sram_gwen;
    data_t sram_wen;
    data_t sram_d;
    data_t sram_q;

    // Controller side.
    modport slave (
        input  init_req, req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        output init_done, req_rdy, rsp_vld, rsp_data,
        output sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

    // Requester / consumer / SRAM side.
    modport master (
        output init_req, req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        input  init_done, req_rdy, rsp_vld, rsp_data,
        input  sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

endinterface

// File: rtl/ct_l2c_spsram_128x104_ctrl_rsp_buf.sv
// Two-entry read-response FIFO; head entry drives the response data directly.
module ct_l2c_spsram_rsp_buf
    import ct_l2c_spsram_128x104_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  data_t      push_data_i,
    input  logic       pop_i,
    output data_t      head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    data_t      mem_q [RSP_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok, pop_ok;

    assign full_o  = (count_q == 2'(RSP_DEPTH));
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Overflowing pushes and underflowing pops are dropped rather than corrupting state.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 2'd1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    // FIFO state and storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/ct_l2c_spsram_128x104_ctrl.sv
// Access controller for the 128x104 single-port SRAM: post-reset/on-demand array clear,
// request-to-strobe conversion and credit-protected read-response buffering.
module ct_l2c_spsram_128x104_ctrl
    import ct_l2c_spsram_128x104_ctrl_pkg::*;
(
    input logic                          forever_cpuclk,
    input logic                          cpurst,
    ct_l2c_spsram_128x104_ctrl_if.slave  bus_io
);

    localparam addr_t InitLast = ADDR_WIDTH'(SRAM_DEPTH - 1);

    ctrl_state_e state_q, state_d;
    addr_t       init_cnt_q, init_cnt_d;
    logic        init_done_q, init_done_d;
    logic        in_flight_q, in_flight_d;

    logic        req_fire;
    logic        rd_fire;
    logic        init_accept;
    logic        credit_ok;
    logic        buf_full;
    logic        buf_empty;
    logic [1:0]  buf_count;
    data_t       buf_head;

    // Conservative credit: a read may be outstanding in the SRAM pipe, so count it as occupied.
    assign credit_ok = ({1'b0, buf_count} + {2'b00, in_flight_q}) < 3'd2;

    assign bus_io.req_rdy   = init_done_q && credit_ok;
    assign bus_io.init_done = init_done_q;
    assign bus_io.rsp_vld   = !buf_empty;
    assign bus_io.rsp_data  = buf_head;

    assign req_fire    = bus_io.req_vld && bus_io.req_rdy;
    assign rd_fire     = req_fire && !bus_io.req_wr;
    // Clear may only restart with an empty SRAM pipe and an idle port.
    assign init_accept = (state_q == StIdle) && bus_io.init_req && !in_flight_q && !req_fire;
    assign in_flight_d = rd_fire;

    // FSM and clear-counter next-state.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == InitLast) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                if (init_accept) begin
                    state_d     = StInit;
                    init_cnt_d  = '0;
                    init_done_d = 1'b0;
                end
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            in_flight_q <= in_flight_d;
        end
    end

    // SRAM strobe mux; reset forces the idle pattern so the array is never touched during reset.
    always_comb begin
        bus_io.sram_cen  = 1'b1;
        bus_io.sram_gwen = 1'b1;
        bus_io.sram_wen  = '1;
        bus_io.sram_a    = '0;
        bus_io.sram_d    = '0;
        if (!cpurst) begin
            if (state_q == StInit) begin
                bus_io.sram_cen  = 1'b0;
                bus_io.sram_gwen = 1'b0;
                bus_io.sram_wen  = '0;
                bus_io.sram_a    = init_cnt_q;
            end else if (req_fire) begin
                bus_io.sram_cen = 1'b0;
                bus_io.sram_a   = bus_io.req_addr;
                if (bus_io.req_wr) begin
                    bus_io.sram_gwen = 1'b0;
                    bus_io.sram_wen  = ~bus_io.req_wmask;
                    bus_io.sram_d    = bus_io.req_wdata;
                end
            end
        end
    end

    ct_l2c_spsram_rsp_buf u_rsp_buf (
        .clk_i       (forever_cpuclk),
        .rst_i       (cpurst),
        .push_i      (in_flight_q && !buf_full),
        .push_data_i (bus_io.sram_q),
        .pop_i       (bus_io.rsp_vld && bus_io.rsp_rdy),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

endmodule

// File: tb/tb_ct_l2c_spsram_128x104_ctrl.sv
// Directed bench for the SPSRAM access controller with a behavioural 128x104 SRAM model.
module tb_ct_l2c_spsram_128x104_ctrl;
    import ct_l2c_spsram_128x104_ctrl_pkg::*;

    logic  clk;
    logic  rst;
    int    tests;
    int    fails;
    data_t mem [SRAM_DEPTH];
    data_t sram_q_r;
    data_t d30, d31, d32, da5, d1234;

    ct_l2c_spsram_128x104_ctrl_if u_if ();

    ct_l2c_spsram_128x104_ctrl u_dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus_io         (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: per-bit active-low write mask, Q registered on a read.
    initial begin
        for (int i = 0; i < int'(SRAM_DEPTH); i++) mem[i] = '1;
        sram_q_r = '0;
    end
    always @(posedge clk) begin
        if (!u_if.sram_cen) begin
            if (!u_if.sram_gwen) begin
                mem[u_if.sram_a] <= (mem[u_if.sram_a] & u_if.sram_wen) |
                                    (u_if.sram_d & ~u_if.sram_wen);
            end else begin
                sram_q_r <= mem[u_if.sram_a];
            end
        end
    end
    assign u_if.sram_q = sram_q_r;

    task automatic chk(input string tag, input data_t obs, input data_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 128 clear cycles starting in the current cycle; counts cycles that deviate.
    task automatic init_sweep(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < int'(SRAM_DEPTH); i++) begin
            #1;
            if (u_if.sram_cen !== 1'b0 || u_if.sram_gwen !== 1'b0 || u_if.sram_wen !== '0 ||
                u_if.sram_d !== '0 || u_if.sram_a !== ADDR_WIDTH'(i) || u_if.req_rdy !== 1'b0)
                bad++;
            tick();
        end
        chk(tag, DATA_WIDTH'(bad), '0);
        #1;
        chk1({tag, "_done"}, u_if.init_done, 1'b1);
        chk1({tag, "_cen_idle"}, u_if.sram_cen, 1'b1);
    endtask

    task automatic drive(input logic vld, input logic wr, input addr_t a, input data_t wd,
                         input data_t wm);
        u_if.req_vld   = vld;
        u_if.req_wr    = wr;
        u_if.req_addr  = a;
        u_if.req_wdata = wd;
        u_if.req_wmask = wm;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        da5   = {13{8'hA5}};
        d30   = {13{8'h30}};
        d31   = {13{8'h31}};
        d32   = {13{8'h32}};
        d1234 = DATA_WIDTH'(16'h1234);
        rst   = 1'b1;
        u_if.init_req = 1'b0;
        u_if.rsp_rdy  = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_init_done", u_if.init_done, 1'b0);
        chk1("rst_req_rdy", u_if.req_rdy, 1'b0);
        chk1("rst_rsp_vld", u_if.rsp_vld, 1'b0);
        chk("rst_rsp_data", u_if.rsp_data, '0);
        chk1("rst_cen", u_if.sram_cen, 1'b1);
        chk("rst_wen", u_if.sram_wen, '1);
        rst = 1'b0;
        init_sweep("init_after_reset");
        chk1("idle_req_rdy", u_if.req_rdy, 1'b1);

        // Full write to addr 5, then read back next cycle.
        drive(1'b1, 1'b1, 7'd5, da5, '1);
        #1;
        chk1("wr5_cen", u_if.sram_cen, 1'b0);
        chk1("wr5_gwen", u_if.sram_gwen, 1'b0);
        chk("wr5_wen", u_if.sram_wen, '0);
        chk("wr5_a", DATA_WIDTH'(u_if.sram_a), DATA_WIDTH'(5));
        chk("wr5_d", u_if.sram_d, da5);
        tick();
        drive(1'b1, 1'b0, 7'd5, '0, '0);
        #1;
        chk1("rd5_gwen", u_if.sram_gwen, 1'b1);
        chk("rd5_wen", u_if.sram_wen, '1);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        chk1("rd5_vld_edge1", u_if.rsp_vld, 1'b0);
        tick();
        chk1("rd5_vld_edge2", u_if.rsp_vld, 1'b1);
        chk("rd5_data", u_if.rsp_data, da5);
        tick();
        chk1("rd5_popped", u_if.rsp_vld, 1'b0);

        // Partial write of the low byte into a cleared entry.
        drive(1'b1, 1'b1, 7'd20, '1, DATA_WIDTH'(8'hFF));
        #1;
        chk("pw_wen", u_if.sram_wen, ~DATA_WIDTH'(8'hFF));
        tick();
        drive(1'b1, 1'b0, 7'd20, '0, '0);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("pw_data", u_if.rsp_data, DATA_WIDTH'(8'hFF));
        tick();

        // Back-pressure: preload three entries, then read with rsp_rdy low.
        drive(1'b1, 1'b1, 7'd30, d30, '1); tick();
        drive(1'b1, 1'b1, 7'd31, d31, '1); tick();
        drive(1'b1, 1'b1, 7'd32, d32, '1); tick();
        u_if.rsp_rdy = 1'b0;
        drive(1'b1, 1'b0, 7'd30, '0, '0);
        #1; chk1("bp_rdy0", u_if.req_rdy, 1'b1);
        tick();
        drive(1'b1, 1'b0, 7'd31, '0, '0);
        #1; chk1("bp_rdy1", u_if.req_rdy, 1'b1);
        tick();
        drive(1'b1, 1'b0, 7'd32, '0, '0);
        #1; chk1("bp_rdy2_blocked", u_if.req_rdy, 1'b0);
        tick();
        chk1("bp_full_rdy", u_if.req_rdy, 1'b0);
        chk("bp_head0", u_if.rsp_data, d30);
        tick();
        chk("bp_head_stable", u_if.rsp_data, d30);
        chk1("bp_still_blocked", u_if.req_rdy, 1'b0);
        u_if.rsp_rdy = 1'b1;
        tick();
        chk("bp_head1", u_if.rsp_data, d31);
        chk1("bp_rdy_reopen", u_if.req_rdy, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        chk1("bp_empty_gap", u_if.rsp_vld, 1'b0);
        tick();
        chk("bp_head2", u_if.rsp_data, d32);
        tick();
        chk1("bp_drained", u_if.rsp_vld, 1'b0);

        // Back-to-back reads: simultaneous push and pop keep order.
        drive(1'b1, 1'b0, 7'd30, '0, '0); tick();
        drive(1'b1, 1'b0, 7'd31, '0, '0); tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        chk("b2b_first", u_if.rsp_data, d30);
        tick();
        chk1("b2b_vld", u_if.rsp_vld, 1'b1);
        chk("b2b_second", u_if.rsp_data, d31);
        tick();

        // init_req during an in-flight read is ignored; buffered data drains during INIT.
        drive(1'b1, 1'b1, 7'd9, d1234, '1); tick();
        drive(1'b1, 1'b0, 7'd9, '0, '0); tick();
        drive(1'b0, 1'b0, '0, '0, '0);
        u_if.rsp_rdy  = 1'b0;
        u_if.init_req = 1'b1;
        tick();
        u_if.init_req = 1'b0;
        chk1("ireq_ignored", u_if.init_done, 1'b1);
        chk("ireq_rd9", u_if.rsp_data, d1234);
        u_if.init_req = 1'b1;
        tick();
        u_if.init_req = 1'b0;
        chk1("ireq_done_drop", u_if.init_done, 1'b0);
        chk1("ireq_buf_kept", u_if.rsp_vld, 1'b1);
        u_if.rsp_rdy = 1'b1;
        init_sweep("init_on_req");
        chk1("ireq_drained", u_if.rsp_vld, 1'b0);
        drive(1'b1, 1'b0, 7'd9, '0, '0); tick();
        drive(1'b0, 1'b0, '0, '0, '0); tick();
        chk("ireq_rd9_cleared", u_if.rsp_data, '0);
        tick();

        // Reset mid-clear at init_cnt 60.
        u_if.init_req = 1'b1;
        tick();
        u_if.init_req = 1'b0;
        repeat (60) tick();
        #1;
        chk("mid_a60", DATA_WIDTH'(u_if.sram_a), DATA_WIDTH'(60));
        rst = 1'b1;
        #1;
        chk1("mid_rst_cen", u_if.sram_cen, 1'b1);
        chk("mid_rst_a", DATA_WIDTH'(u_if.sram_a), '0);
        tick();
        chk1("mid_rst_done", u_if.init_done, 1'b0);
        rst = 1'b0;
        init_sweep("init_after_midreset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
